// File: rtl/power_manager_mc_if.sv
// Channel-side bundle of the multi-channel power manager: command activity,
// drain handshake and thermal input in, per-channel power controls out.
interface power_manager_mc_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned TEMP_W = 8
);
  logic [NUM_CH-1:0]   cmd_valid;
  logic                pd_allow;
  logic [NUM_CH-1:0]   pd_ack;
  logic [TEMP_W-1:0]   temperature;
  logic [NUM_CH-1:0]   pd_req;
  logic [NUM_CH-1:0]   pd_ready;
  logic [NUM_CH-1:0]   cke;
  logic [NUM_CH-1:0]   sr_en;
  logic [NUM_CH-1:0]   cmd_stall;
  logic [3*NUM_CH-1:0] ch_state;
  logic                low_power_mode;

  modport master (
    output cmd_valid, pd_allow, pd_ack, temperature,
    input  pd_req, pd_ready, cke, sr_en, cmd_stall, ch_state, low_power_mode
  );

  modport slave (
    input  cmd_valid, pd_allow, pd_ack, temperature,
    output pd_req, pd_ready, cke, sr_en, cmd_stall, ch_state, low_power_mode
  );
endinterface

// File: rtl/power_manager_mc.sv
// Per-channel idle tracking and power-down / self-refresh FSMs with timed exit,
// plus a shared thermal throttle that halves the power-down entry threshold.
module power_manager_mc #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned IDLE_W      = 16,
  parameter int unsigned IDLE_THRESH = 1000,
  parameter int unsigned SR_THRESH   = 8000,
  parameter int unsigned EXIT_LAT    = 8,
  parameter int unsigned SR_EXIT_LAT = 32,
  parameter int unsigned TEMP_W      = 8,
  parameter int unsigned TEMP_HI     = 70,
  parameter int unsigned TEMP_LO     = 65
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  power_manager_mc_if.slave bus
);

  localparam int unsigned EXIT_MAX = (SR_EXIT_LAT > EXIT_LAT) ? SR_EXIT_LAT : EXIT_LAT;
  localparam int unsigned EXIT_W   = (EXIT_MAX > 1) ? $clog2(EXIT_MAX) : 1;

  localparam logic [IDLE_W-1:0] THR_FULL   = IDLE_W'(IDLE_THRESH);
  localparam logic [IDLE_W-1:0] THR_HALF   = IDLE_W'(IDLE_THRESH >> 1);
  localparam logic [IDLE_W-1:0] THR_SR     = IDLE_W'(SR_THRESH);
  localparam logic [EXIT_W-1:0] EXIT_LD    = EXIT_W'(EXIT_LAT - 1);
  localparam logic [EXIT_W-1:0] SR_EXIT_LD = EXIT_W'(SR_EXIT_LAT - 1);
  localparam logic [TEMP_W-1:0] T_HI       = TEMP_W'(TEMP_HI);
  localparam logic [TEMP_W-1:0] T_LO       = TEMP_W'(TEMP_LO);

  typedef enum logic [2:0] {
    ST_ACTIVE  = 3'd0,
    ST_ENTER   = 3'd1,
    ST_PWRDN   = 3'd2,
    ST_SELFREF = 3'd3,
    ST_EXIT    = 3'd4
  } state_t;

  state_t            r_state    [NUM_CH];
  logic [IDLE_W-1:0] r_idle     [NUM_CH];
  logic [EXIT_W-1:0] r_exit     [NUM_CH];
  state_t            w_nxt      [NUM_CH];
  logic [IDLE_W-1:0] w_idle_nxt [NUM_CH];
  logic [EXIT_W-1:0] w_exit_nxt [NUM_CH];

  logic                r_lpm;
  logic [NUM_CH-1:0]   r_pd_req;
  logic [NUM_CH-1:0]   r_cke;
  logic [NUM_CH-1:0]   r_sr_en;
  logic [NUM_CH-1:0]   r_stall;
  logic [IDLE_W-1:0]   w_thr;
  logic [NUM_CH-1:0]   w_ready;
  logic [3*NUM_CH-1:0] w_ch_state;

  always_comb begin
    w_thr      = r_lpm ? THR_HALF : THR_FULL;
    w_ready    = '0;
    w_ch_state = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_ready[i]            = (r_idle[i] >= w_thr);
      w_ch_state[3*i +: 3]  = r_state[i];
      w_nxt[i]              = r_state[i];
      w_exit_nxt[i]         = r_exit[i];
      if (bus.cmd_valid[i])
        w_idle_nxt[i] = '0;
      else if (r_idle[i] != '1)
        w_idle_nxt[i] = r_idle[i] + 1'b1;
      else
        w_idle_nxt[i] = r_idle[i];

      case (r_state[i])
        ST_ACTIVE: begin
          if (w_ready[i] && bus.pd_allow && !bus.cmd_valid[i])
            w_nxt[i] = ST_ENTER;
        end
        // Abort on fresh activity wins over a drain acknowledge in the same cycle.
        ST_ENTER: begin
          if (bus.cmd_valid[i])
            w_nxt[i] = ST_ACTIVE;
          else if (bus.pd_ack[i])
            w_nxt[i] = ST_PWRDN;
        end
        ST_PWRDN: begin
          if (bus.cmd_valid[i]) begin
            w_nxt[i]      = ST_EXIT;
            w_exit_nxt[i] = EXIT_LD;
          end else if (r_idle[i] >= THR_SR) begin
            w_nxt[i] = ST_SELFREF;
          end
        end
        ST_SELFREF: begin
          if (bus.cmd_valid[i]) begin
            w_nxt[i]      = ST_EXIT;
            w_exit_nxt[i] = SR_EXIT_LD;
          end
        end
        ST_EXIT: begin
          if (r_exit[i] == '0) begin
            w_nxt[i]      = ST_ACTIVE;
            w_idle_nxt[i] = '0;
          end else begin
            w_exit_nxt[i] = r_exit[i] - 1'b1;
          end
        end
        default: w_nxt[i] = ST_ACTIVE;
      endcase
    end
  end

  // Channel outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_state[i] <= ST_ACTIVE;
        r_idle[i]  <= '0;
        r_exit[i]  <= '0;
      end
      r_lpm    <= 1'b0;
      r_pd_req <= '0;
      r_cke    <= '1;
      r_sr_en  <= '0;
      r_stall  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_state[i]  <= w_nxt[i];
        r_idle[i]   <= w_idle_nxt[i];
        r_exit[i]   <= w_exit_nxt[i];
        r_pd_req[i] <= (w_nxt[i] == ST_ENTER);
        r_cke[i]    <= !((w_nxt[i] == ST_PWRDN) || (w_nxt[i] == ST_SELFREF));
        r_sr_en[i]  <= (w_nxt[i] == ST_SELFREF);
        r_stall[i]  <= (w_nxt[i] != ST_ACTIVE);
      end
      if (bus.temperature >= T_HI)
        r_lpm <= 1'b1;
      else if (bus.temperature < T_LO)
        r_lpm <= 1'b0;
    end
  end

  assign bus.pd_req         = r_pd_req;
  assign bus.pd_ready       = w_ready;
  assign bus.cke            = r_cke;
  assign bus.sr_en          = r_sr_en;
  assign bus.cmd_stall      = r_stall;
  assign bus.ch_state       = w_ch_state;
  assign bus.low_power_mode = r_lpm;

endmodule

// File: tb/tb_power_manager_mc.sv
// Bench for power_manager_mc: directed scenarios then random traffic, every
// cycle compared against a cycle-level behavioural model of the channels.
module tb_power_manager_mc;

  localparam int NCH     = 2;
  localparam int IW      = 8;
  localparam int THR     = 10;
  localparam int SR      = 30;
  localparam int XLAT    = 4;
  localparam int SRXLAT  = 12;
  localparam int IDLEMAX = (1 << IW) - 1;

  logic           clk;
  logic           rst_n;
  logic [NCH-1:0] cv;
  logic           allow;
  logic [NCH-1:0] ack;
  logic [7:0]     temp;

  int n_cmp;
  int n_err;

  // Model state: 0 active, 1 enter, 2 power-down, 3 self-refresh, 4 exit.
  int m_st   [NCH];
  int m_idle [NCH];
  int m_rem  [NCH];
  bit m_lpm;

  power_manager_mc_if #(.NUM_CH(NCH), .TEMP_W(8)) bus ();

  power_manager_mc #(
    .NUM_CH(NCH), .IDLE_W(IW), .IDLE_THRESH(THR), .SR_THRESH(SR),
    .EXIT_LAT(XLAT), .SR_EXIT_LAT(SRXLAT), .TEMP_W(8),
    .TEMP_HI(70), .TEMP_LO(65)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  assign bus.cmd_valid   = cv;
  assign bus.pd_allow    = allow;
  assign bus.pd_ack      = ack;
  assign bus.temperature = temp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_st[i] = 0; m_idle[i] = 0; m_rem[i] = 0;
    end
    m_lpm = 1'b0;
  endtask

  task automatic model_step();
    int thr_now;
    int ns, ni, nr;
    thr_now = m_lpm ? THR / 2 : THR;
    for (int i = 0; i < NCH; i++) begin
      ns = m_st[i];
      nr = m_rem[i];
      ni = cv[i] ? 0 : ((m_idle[i] >= IDLEMAX) ? IDLEMAX : m_idle[i] + 1);
      case (m_st[i])
        0: if (m_idle[i] >= thr_now && allow && !cv[i]) ns = 1;
        1: if (cv[i]) ns = 0; else if (ack[i]) ns = 2;
        2: if (cv[i]) begin ns = 4; nr = XLAT; end else if (m_idle[i] >= SR) ns = 3;
        3: if (cv[i]) begin ns = 4; nr = SRXLAT; end
        default: begin
          nr = m_rem[i] - 1;
          if (nr == 0) begin ns = 0; ni = 0; end
        end
      endcase
      m_st[i] = ns; m_idle[i] = ni; m_rem[i] = nr;
    end
    if (temp >= 70) m_lpm = 1'b1;
    else if (temp < 65) m_lpm = 1'b0;
  endtask

  task automatic check_all();
    logic [3*NCH-1:0] e_state;
    logic [NCH-1:0]   e_req, e_rdy, e_cke, e_sr, e_stall;
    int thr_now;
    thr_now = m_lpm ? THR / 2 : THR;
    for (int i = 0; i < NCH; i++) begin
      e_state[3*i +: 3] = m_st[i][2:0];
      e_req[i]   = (m_st[i] == 1);
      e_rdy[i]   = (m_idle[i] >= thr_now);
      e_cke[i]   = !(m_st[i] == 2 || m_st[i] == 3);
      e_sr[i]    = (m_st[i] == 3);
      e_stall[i] = (m_st[i] != 0);
    end
    check_eq("ch_state",  32'(bus.ch_state),  32'(e_state));
    check_eq("pd_req",    32'(bus.pd_req),    32'(e_req));
    check_eq("pd_ready",  32'(bus.pd_ready),  32'(e_rdy));
    check_eq("cke",       32'(bus.cke),       32'(e_cke));
    check_eq("sr_en",     32'(bus.sr_en),     32'(e_sr));
    check_eq("cmd_stall", 32'(bus.cmd_stall), 32'(e_stall));
    check_eq("lpm",       32'(bus.low_power_mode), 32'(m_lpm));
  endtask

  // One clock: inputs already set, model follows the edge, outputs checked mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_ch0_state(input string tag, input logic [2:0] want);
    int k;
    k = 0;
    while (bus.ch_state[2:0] != want && k < 60) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(bus.ch_state[2:0]), 32'(want));
  endtask

  task automatic measure_exit(input string tag, input int exp_len);
    int n;
    n = 0;
    cv[0] = 1'b0;
    while (bus.ch_state[2:0] == 3'd4 && n < 60) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(n), 32'(exp_len));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    cv    = 2'b10;
    allow = 1'b1;
    ack   = 2'b11;
    temp  = 8'd25;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // ch0 idles into power-down while ch1 stays busy.
    idle_cycles(14);
    check_eq("ch0_pwrdn", 32'(bus.ch_state[2:0]), 32'd2);

    // Wake from power-down.
    cv[0] = 1'b1;
    tick();
    measure_exit("pd_exit_len", XLAT);

    // Long idle into self-refresh, through idle-counter saturation, then wake.
    idle_cycles(45);
    check_eq("ch0_sr", 32'(bus.sr_en[0]), 32'd1);
    idle_cycles(240);
    cv[0] = 1'b1;
    tick();
    measure_exit("sr_exit_len", SRXLAT);

    // Entry abort racing a drain acknowledge.
    ack = 2'b00;
    wait_ch0_state("reach_enter", 3'd1);
    cv[0] = 1'b1;
    ack   = 2'b11;
    tick();
    check_eq("abort_state", 32'(bus.ch_state[2:0]), 32'd0);
    cv[0] = 1'b0;

    // Thermal hysteresis: set, hold in band, clear.
    temp = 8'd70;
    idle_cycles(10);
    temp = 8'd67;
    cv[0] = 1'b1; tick(); cv[0] = 1'b0;
    idle_cycles(15);
    check_eq("lpm_hold", 32'(bus.low_power_mode), 32'd1);
    temp = 8'd64;
    cv[0] = 1'b1; tick(); cv[0] = 1'b0;
    idle_cycles(25);

    // Global disable holds ACTIVE while readiness still reports.
    allow = 1'b0;
    cv[0] = 1'b1; tick(); cv[0] = 1'b0;
    idle_cycles(30);
    check_eq("noallow_state", 32'(bus.ch_state[2:0]), 32'd0);
    allow = 1'b1;
    wait_ch0_state("reach_pwrdn", 3'd2);
    cv[0] = 1'b1; tick(); cv[0] = 1'b0;
    check_eq("in_exit", 32'(bus.ch_state[2:0]), 32'd4);

    // Asynchronous reset mid-exit, sampled between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_state", 32'(bus.ch_state), 32'd0);
    check_eq("arst_cke",   32'(bus.cke),      32'd3);
    check_eq("arst_stall", 32'(bus.cmd_stall), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        cv[i]  = ($urandom_range(0, 15) == 0);
        ack[i] = ($urandom_range(0, 2) != 0);
      end
      allow = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) temp = 8'($urandom_range(55, 80));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
